// File: rtl/maze_pkg.sv
`default_nettype none
// =====================================================================
// maze_pkg : shared types and constants for the step BCD converter
// Revision : 1.0
// =====================================================================
package maze_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam int          BCD_DIGIT_W = 4;
  localparam logic [15:0] BCD_MAX_4   = 16'h9999;
  localparam int          BIN_MAX_4   = 9999;

  // Largest binary value representable in the given number of decimal digits.
  function automatic int sat_value(input int digits);
    int r;
    r = 1;
    for (int i = 0; i < digits; i++) r = r * 10;
    return r - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/step_bcd_converter_if.sv
`default_nettype none
// =====================================================================
// step_bcd_converter_if : step input and BCD display outputs
// Revision : 1.0
// =====================================================================
interface step_bcd_converter_if #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 4
);
  logic [IN_W-1:0]     steps;
  logic [4*DIGITS-1:0] bcd;
  logic                bcd_valid;
  logic                busy;

  modport master (output steps, input bcd, input bcd_valid, input busy);
  modport slave  (input steps, output bcd, output bcd_valid, output busy);
endinterface
`default_nettype wire

// File: rtl/step_bcd_converter_add3.sv
`default_nettype none
// =====================================================================
// bcd_add3 : double-dabble digit corrector (d >= 5 ? d + 3 : d)
// Revision : 1.0
// =====================================================================
module bcd_add3 (
  input  wire logic [3:0] d,
  output logic      [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule
`default_nettype wire

// File: rtl/step_bcd_converter.sv
`default_nettype none
// =====================================================================
// step_bcd_converter : multi-cycle saturating binary-to-BCD converter
// Revision : 1.0
// =====================================================================
module step_bcd_converter
  import maze_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int DIGITS = 4
) (
  input  wire logic           clk,
  input  wire logic           clr_n,
  step_bcd_converter_if.slave conv
);

  localparam int          ACC_W   = BCD_DIGIT_W * DIGITS;
  localparam int          CNT_W   = $clog2(IN_W + 1);
  localparam logic [31:0] SAT_BIN = (DIGITS == 4) ? 32'(BIN_MAX_4) : 32'(sat_value(DIGITS));
  localparam logic [IN_W-1:0] SAT_IN = SAT_BIN[IN_W-1:0];

  conv_state_t      state;
  logic [IN_W-1:0]  last_conv;
  logic [IN_W-1:0]  bin;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] bcd_q;
  logic             bcd_valid_q;
  logic             busy_q;

  logic [ACC_W-1:0]      acc_adj;
  logic [IN_W-1:0]       clamped;
  logic [ACC_W+IN_W-1:0] shift_vec;

  assign clamped   = (32'(conv.steps) > SAT_BIN) ? SAT_IN : conv.steps;
  assign shift_vec = {acc_adj, bin} << 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .d (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // last_conv holds the raw input so a change above the clamp still re-converts.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= IDLE;
      last_conv   <= '0;
      bin         <= '0;
      acc         <= '0;
      cnt         <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      bcd_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (conv.steps != last_conv) begin
            last_conv <= conv.steps;
            bin       <= clamped;
            acc       <= '0;
            cnt       <= CNT_W'(IN_W);
            busy_q    <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= shift_vec[ACC_W+IN_W-1:IN_W];
          bin <= shift_vec[IN_W-1:0];
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          bcd_q       <= acc;
          bcd_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign conv.bcd       = bcd_q;
  assign conv.bcd_valid = bcd_valid_q;
  assign conv.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_step_bcd_converter.sv
`default_nettype none
// =====================================================================
// tb_step_bcd_converter : directed self-checking bench for the converter
// Revision : 1.0
// =====================================================================
module tb_step_bcd_converter;

  logic clk;
  logic clr_n;
  int   n_pass;
  int   n_total;

  step_bcd_converter_if #(.IN_W(16), .DIGITS(4)) bus ();

  step_bcd_converter #(.IN_W(16), .DIGITS(4)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .conv  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 5000000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000 % 10), 4'(s / 100 % 10), 4'(s / 10 % 10), 4'(s % 10)};
  endfunction

  // Called at a negedge with the DUT idle; walks E0..E18 checking each phase.
  task automatic conv(input logic [15:0] v, input logic [15:0] exp, input string tag);
    logic [15:0] old;
    bit          held;
    old  = bus.bcd;
    held = 1'b1;
    bus.steps = v;
    @(posedge clk); @(negedge clk);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus.bcd_valid !== 1'b0 || bus.bcd !== old || bus.busy !== 1'b1) held = 1'b0;
    end
    chk({tag, "_hold"}, 32'(held), 32'd1);
    @(posedge clk); @(negedge clk);
    chk({tag, "_valid"}, 32'(bus.bcd_valid), 32'd1);
    chk({tag, "_bcd"}, 32'(bus.bcd), 32'(exp));
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.bcd_valid), 32'd0);
  endtask

  task automatic wait_valid(input int budget, output int edges);
    edges = 0;
    do begin
      @(posedge clk); @(negedge clk);
      edges++;
    end while (bus.bcd_valid !== 1'b1 && edges < budget);
  endtask

  initial begin
    bit          quiet;
    int          n_pulse;
    int          p_edge [2];
    logic [15:0] p_val  [2];
    int          lat;

    n_pass  = 0;
    n_total = 0;
    clr_n   = 1'b0;
    bus.steps = '0;
    p_edge  = '{0, 0};
    p_val   = '{16'h0, 16'h0};

    // Reset, then hold steps at zero: nothing may convert.
    repeat (3) @(negedge clk);
    chk("rst_bcd", 32'(bus.bcd), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.bcd_valid), 32'd0);
    clr_n = 1'b1;
    quiet = 1'b1;
    repeat (50) begin
      @(posedge clk); @(negedge clk);
      if (bus.bcd_valid !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    chk("zero_quiet", 32'(quiet), 32'd1);
    chk("zero_bcd", 32'(bus.bcd), 32'h0);

    conv(16'd1234,  16'h1234, "c1234");
    conv(16'd9999,  16'h9999, "c9999");
    conv(16'd10000, 16'h9999, "c10000");
    conv(16'd65535, 16'h9999, "c65535");

    // 7 then 8 arriving before E3: two conversions, at E17 and E35.
    n_pulse = 0;
    bus.steps = 16'd7;
    for (int e = 0; e < 45; e++) begin
      @(posedge clk); @(negedge clk);
      if (e == 2) bus.steps = 16'd8;
      if (bus.bcd_valid === 1'b1) begin
        if (n_pulse < 2) begin
          p_edge[n_pulse] = e;
          p_val[n_pulse]  = bus.bcd;
        end
        n_pulse++;
      end
    end
    chk("mid_pulses", 32'(n_pulse), 32'd2);
    chk("mid_edge0", 32'(p_edge[0]), 32'd17);
    chk("mid_val0", 32'(p_val[0]), 32'h0007);
    chk("mid_edge1", 32'(p_edge[1]), 32'd35);
    chk("mid_val1", 32'(p_val[1]), 32'h0008);

    // Reset asserted mid-SHIFT discards the conversion immediately.
    bus.steps = 16'd4321;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
    end
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    clr_n = 1'b0;
    #1;
    chk("arst_bcd", 32'(bus.bcd), 32'h0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_valid", 32'(bus.bcd_valid), 32'd0);
    quiet = 1'b1;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      if (bus.bcd_valid !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    chk("arst_quiet", 32'(quiet), 32'd1);
    clr_n = 1'b1;
    conv(16'd4321, 16'h4321, "c4321");

    // Sweep two windows, each new value applied right after the previous result.
    for (int v = 0; v <= 10050; v++) begin
      if (v == 200) v = 9900;
      bus.steps = 16'(v);
      wait_valid(40, lat);
      chk($sformatf("sweep_valid_%0d", v), 32'(bus.bcd_valid), 32'd1);
      chk($sformatf("sweep_bcd_%0d", v), 32'(bus.bcd), 32'(to_bcd(v)));
      chk($sformatf("sweep_lat_%0d", v), 32'(lat), 32'd18);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/step_bcd_converter.md
# step_bcd_converter

Sequential binary-to-BCD converter between the step counter in the VGA/game logic and the four-digit seven-segment driver. It watches the 16-bit step count and re-converts it with a multi-cycle double-dabble whenever it changes. It presents a registered four-digit packed-BCD word, saturated at 9999, that the display driver consumes directly. It replaces the combinational step-to-display mapping, removing the long add-3 chain from the 50 MHz path.

## Interface
- IN_W, 16: width of the binary step input.
- DIGITS, 4: number of BCD digits produced; saturation value is 10^DIGITS−1.
- clk  input  1  master 50 MHz clock; all state on rising edge.
- clr_n  input  1  reset, asynchronous assert, active-low (one clock; reset is asynchronous and active-low).
- steps  input  IN_W  binary step count; may change on any cycle.
- bcd  output  4*DIGITS  packed BCD, digit 0 in bits [3:0], registered.
- bcd_valid  output  1  one-cycle pulse when bcd is updated.
- busy  output  1  high while a conversion is in progress.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: compare steps against last_conv, the value of the last accepted input, raw and unclamped.
  - If different: latch steps into last_conv and load the shift register with min(steps, 10^DIGITS−1).
  - Clear the BCD accumulator, load iteration counter = IN_W, go to SHIFT.
  - If equal: stay in IDLE.
- SHIFT, one iteration per cycle:
  - Add 3 to every accumulator digit ≥ 5, combinationally.
  - Shift {accumulator, binary} left by one and decrement the counter.
  - Go to DONE when the counter reaches 1 on this cycle, i.e. after exactly IN_W shift cycles.
- DONE: copy the accumulator to bcd, pulse bcd_valid, return to IDLE.
- Saturation:
  - Any input > 10^DIGITS−1 yields all-nines, 0x9999 at the defaults.
  - A clamped value never exceeds DIGITS digits, so no overflow digit is kept.
- Input changes during SHIFT/DONE are ignored. On return to IDLE, the current steps is compared against last_conv, so the final value is always converted. Intermediate values may be skipped.
- bcd holds its value between conversions; it never shows a partial result.
- Reset, asynchronous, from any state:
  - state = IDLE, last_conv = 0, accumulator and shift register = 0.
  - Outputs: bcd = 0, bcd_valid = 0, busy = 0.
  - An in-flight conversion is discarded.
  - Since bcd = 0 matches last_conv = 0, steps = 0 after reset triggers no conversion.

## Timing
- An input change first seen in IDLE at edge E0 is latched at E0 (busy = 1 after E0).
- IN_W SHIFT edges follow, E1..E16 at the default width.
- DONE edge E17: bcd and bcd_valid = 1 visible after E17; busy = 0 after E17.
- Conversion latency: IN_W+1 cycles from the latch edge; bcd_valid is high for exactly one cycle.
- Back-to-back throughput: one conversion per IN_W+2 cycles, since IDLE takes one cycle to re-sample.
- Wait-free: no handshake from the consumer. bcd is always safe to sample.
- Deassertion of clr_n is synchronised externally; first IDLE compare occurs on the first edge after release.

## Structure
- Shared package maze_pkg holds:
  - the state enum (IDLE/SHIFT/DONE);
  - BCD digit width = 4;
  - helper constant for saturation, BCD_MAX_4 = 16'h9999 and the binary 9999.
- One natural sub-module: bcd_add3, a combinational 4-bit digit corrector (d ≥ 5 ? d+3 : d), instantiated DIGITS times via generate.
- Counter width: $clog2(IN_W+1).

## Test plan
- Reset, hold steps = 0 for 50 cycles → bcd = 0x0000, bcd_valid never asserts, busy stays 0.
- steps 0→1234 at E0 → busy after E0, bcd = 0x1234 with single bcd_valid pulse after E17; bcd unchanged before then.
- steps = 9999, then 10000, then 65535, each after completion:
  - first → 0x9999;
  - second → a conversion runs (raw value changed), result 0x9999;
  - third → 0x9999.
- steps = 7 then 8 at E3 (mid-conversion) → first result 0x0007, then a second conversion starting at the IDLE cycle gives 0x0008; exactly two valid pulses.
- clr_n low during SHIFT with steps = 4321:
  - immediately bcd = 0, busy = 0, no valid pulse;
  - after release, conversion restarts and yields 0x4321 IN_W+1 cycles after the latch.
- Sweep steps 0..10050 incrementing after each bcd_valid → each bcd equals the decimal value, saturating at 0x9999 from 9999 on.
